// File: rtl/nibble_serial_accumulator.sv
// Serial WIDTH-bit add/subtract built around one 4-bit carry-lookahead slice, one nibble per clock.
// Optional saturation on signed overflow is enabled by defining MAC_ACC_SATURATE_EN.
module nibble_serial_accumulator #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    input  logic             acc_mode,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [WIDTH-1:0] acc
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             acc_mode_q, acc_mode_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [4:0]       slice;
    logic [WIDTH-1:0] full;
    logic             ovf_calc;
    logic [WIDTH-1:0] final_sum;

    // Returns {carry_out, sum[3:0]} using explicit generate/propagate lookahead terms.
    function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic c0);
        logic [3:0] p;
        logic [3:0] g;
        logic [4:0] c;
        p    = a ^ b;
        g    = a & b;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c[4], p ^ c[3:0]};
    endfunction

    always_comb begin
        slice    = cla4(a_q[{cnt_q, 2'b00} +: 4], b_q[{cnt_q, 2'b00} +: 4], carry_q);
        full     = res_q;
        full[{cnt_q, 2'b00} +: 4] = slice[3:0];
        ovf_calc = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (full[WIDTH-1] != a_q[WIDTH-1]);
`ifdef MAC_ACC_SATURATE_EN
        if (ovf_calc) begin
            final_sum = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            final_sum = full;
        end
`else
        final_sum = full;
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        res_d       = res_q;
        acc_mode_d  = acc_mode_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        acc_d       = acc_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (clear) begin
                    acc_d = '0;
                end
                // A clear in the accepting cycle must already be visible to an accumulate operand.
                if (in_valid && in_ready_q) begin
                    a_d        = acc_mode ? (clear ? '0 : acc_q) : op_a;
                    b_d        = sub ? ~op_b : op_b;
                    carry_d    = sub;
                    cnt_d      = '0;
                    acc_mode_d = acc_mode;
                    ovf_d      = 1'b0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            RUN: begin
                res_d   = full;
                carry_d = slice[4];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d       = '0;
                    sum_d       = final_sum;
                    cout_d      = slice[4];
                    ovf_d       = ovf_calc;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (acc_mode_q) begin
                        acc_d = sum_q;
                    end
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            res_q       <= '0;
            acc_mode_q  <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            acc_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            res_q       <= res_d;
            acc_mode_q  <= acc_mode_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign acc       = acc_q;

endmodule

// File: tb/tb_nibble_serial_accumulator.sv
// Self-checking bench for nibble_serial_accumulator (WIDTH=16) against an arithmetic reference model.
module tb_nibble_serial_accumulator;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             sub;
    logic             acc_mode;
    logic             clear;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [WIDTH-1:0] acc;

    int passCount  = 0;
    int checkCount = 0;
    logic [WIDTH-1:0] accModel = '0;

    nibble_serial_accumulator #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .acc_mode  (acc_mode),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .acc       (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full transaction: handshake, latency, result fields, optional backpressure, output handshake.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic s, input logic am, input logic clr, input int holdCycles);
        logic [WIDTH-1:0] opA;
        logic [WIDTH-1:0] expSum;
        logic             expCout;
        logic             expOvf;
        logic [WIDTH-1:0] accBefore;
        int               r;
        int               waits;
        int               lat;

        waits = 0;
        while (!in_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        checkOutput("in_ready_wait", {31'd0, in_ready}, 32'd1);

        op_a = a; op_b = b; sub = s; acc_mode = am; clear = clr; in_valid = 1'b1;
        @(posedge clk);

        if (clr) accModel = '0;
        opA     = am ? accModel : a;
        expSum  = s ? (opA - b) : (opA + b);
        expCout = s ? (opA >= b) : ((32'(opA) + 32'(b)) > 32'hFFFF);
        r       = s ? (int'($signed(opA)) - int'($signed(b))) : (int'($signed(opA)) + int'($signed(b)));
        expOvf  = (r > 32767) || (r < -32768);
`ifdef MAC_ACC_SATURATE_EN
        if (expOvf) expSum = opA[WIDTH-1] ? 16'h8000 : 16'h7FFF;
`endif

        @(negedge clk);
        in_valid = 1'b0; clear = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", lat, NIB + 1);
        checkOutput("sum", 32'(sum), 32'(expSum));
        checkOutput("cout", {31'd0, cout}, {31'd0, expCout});
        checkOutput("ovf", {31'd0, ovf}, {31'd0, expOvf});

        accBefore = accModel;
        for (int i = 0; i < holdCycles; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            op_a     = 16'($urandom);
            op_b     = 16'($urandom);
            @(negedge clk);
            checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("hold_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("hold_sum", 32'(sum), 32'(expSum));
            checkOutput("hold_acc", 32'(acc), 32'(accBefore));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        if (am) accModel = expSum;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("valid_drop", {31'd0, out_valid}, 32'd0);
        checkOutput("acc", 32'(acc), 32'(accModel));
        checkOutput("sum_idle_hold", 32'(sum), 32'(expSum));
    endtask

    task automatic doClear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        accModel = '0;
        @(negedge clk);
        clear = 1'b0;
        checkOutput("clear_acc", 32'(acc), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; sub = 1'b0;
        acc_mode = 1'b0; clear = 1'b0; out_ready = 1'b0;
        #23;
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_sum", 32'(sum), 32'd0);
        checkOutput("rst_acc", 32'(acc), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("release_in_ready", {31'd0, in_ready}, 32'd1);

        applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b0, 1'b0, 0);
        applyStimulus(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, 0);

        doClear();
        for (int i = 0; i < 3; i++) applyStimulus(16'hAAAA, 16'h0010, 1'b0, 1'b1, 1'b0, 0);
        checkOutput("acc_x3", 32'(acc), 32'h0030);
        applyStimulus(16'h5555, 16'h0002, 1'b0, 1'b1, 1'b1, 0);
        checkOutput("clear_and_op", 32'(acc), 32'h0002);

        applyStimulus(16'h0100, 16'h0023, 1'b0, 1'b1, 1'b0, 10);

        for (int i = 0; i < 30; i++) begin
            applyStimulus(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                          int'($urandom_range(0, 3)));
        end

        // Abort during the second RUN cycle; the reset must wipe every visible output.
        @(negedge clk);
        op_a = 16'hABCD; op_b = 16'h1111; sub = 1'b0; acc_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        accModel = '0;
        checkOutput("abort_sum", 32'(sum), 32'd0);
        checkOutput("abort_cout", {31'd0, cout}, 32'd0);
        checkOutput("abort_ovf", {31'd0, ovf}, 32'd0);
        checkOutput("abort_acc", 32'(acc), 32'd0);
        checkOutput("abort_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("abort_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_release_ready", {31'd0, in_ready}, 32'd1);
        applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 0);
        checkOutput("post_abort_sum", 32'(sum), 32'h0002);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/nibble_serial_accumulator.md
Name: nibble_serial_accumulator

Overview:
- Sequences one shared 4-bit carry-lookahead adder slice to perform WIDTH-bit add/subtract, one nibble per clock, least significant nibble first.
- Sits in the MAC unit between the multiplier output and the accumulator register.
- Trades WIDTH/4 cycles of latency for a single adder slice.
- Valid/ready handshake on input and output; optional accumulate mode feeds the result back as operand A.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4, minimum 8.
- NIB, WIDTH/4, derived nibble count (localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand presented
- in_ready  output  1  block can accept operands
- op_a  input  WIDTH  operand A (ignored when acc_mode=1)
- op_b  input  WIDTH  operand B
- sub  input  1  1 = A - B, 0 = A + B
- acc_mode  input  1  1 = use internal accumulator as A
- clear  input  1  zero the accumulator (honoured only in IDLE)
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of the MSB nibble
- ovf  output  1  signed two's-complement overflow
- acc  output  WIDTH  current accumulator value

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM goes to IDLE.
  - in_ready=0 while reset is asserted, and 1 in the first cycle after release.
  - out_valid=0; sum, cout, ovf and acc are all 0; nibble counter is 0.
  - Asserting reset mid-operation aborts the operation. No partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1, capture A, B and sub, then go to RUN.
  - A = acc if acc_mode=1, otherwise op_a.
  - B = ~op_b if sub=1, otherwise op_b.
  - Initial carry = sub.
  - Counter is set to 0.
- clear in IDLE: acc is zeroed at the clock edge.
  - If clear and in_valid are both 1 in the same cycle, the clear takes effect first. An acc_mode operation accepted in that cycle uses A=0.
  - clear in RUN or DONE is ignored.
- RUN:
  - in_ready=0.
  - Each cycle, feed nibble[k] of A and B plus the registered carry into the slice.
  - Store the slice sum into result nibble k and register the slice carry-out. Counter increments.
  - After nibble NIB-1 is processed (NIB cycles in RUN), go to DONE.
- DONE:
  - out_valid=1. sum, cout and ovf are stable until the output handshake.
  - cout = final carry. For sub, cout=1 means no borrow.
  - ovf = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]), where B' is the inverted-if-sub operand.
  - On out_ready=1: acc <= sum if the operation had acc_mode=1 (acc is unchanged otherwise). out_valid drops the next cycle and the FSM returns to IDLE.
- Latency:
  - Input handshake at cycle T; out_valid first high at cycle T+NIB+1.
  - Throughput is one operation per NIB+2 cycles when out_ready is held at 1.
- No pipelining: a new operand is not accepted while in RUN or DONE.
- sum and cout hold their last values in IDLE. ovf is cleared when the next operation is accepted.
- Arithmetic is modulo 2^WIDTH. The carry out of the MSB nibble is not stored in acc.

Optional Feature:
- Macro: MAC_ACC_SATURATE_EN.
- Defined: when ovf=1 in DONE, sum is replaced by 0x7FFF… if A[MSB]=0, or 0x8000… if A[MSB]=1. acc receives the saturated value. ovf is still reported as 1 and cout is unchanged.
- Not defined: sum wraps modulo 2^WIDTH; no saturation logic is present.

Test Plan (WIDTH=16):
- Reset, then add op_a=0x1234, op_b=0x4321, sub=0 -> out_valid exactly 5 cycles after the handshake; sum=0x5555, cout=0, ovf=0.
- Ripple across all nibbles: 0xFFFF + 0x0001 -> sum=0x0000, cout=1, ovf=0. Then 0x7FFF + 0x0001 -> sum=0x8000 (0x7FFF with MAC_ACC_SATURATE_EN), ovf=1.
- Subtract 0x0005 - 0x0007 -> sum=0xFFFE, cout=0. Subtract 0x8000 - 0x0001 -> ovf=1, sum=0x7FFF (0x8000 with saturation).
- Accumulate: clear, then acc_mode=1 with op_b=0x0010, repeated 3 times -> acc=0x0030. clear+in_valid in the same cycle with op_b=0x0002 -> acc=0x0002.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid, sum and acc stable; in_ready=0 throughout; in_valid pulses are ignored.
- Assert rst_n=0 during the second RUN cycle -> all outputs 0 immediately. After release, an op 0x0001+0x0001 returns sum=0x0002 with no trace of the aborted operation.
